// File: rtl/cvxif_copro_responder.sv
// ---------------------------------------------------------------------------
// cvxif_copro_responder
//
// Coprocessor (responder) side of the CoreV-X-Interface offload path.
// Decodes custom-3 instructions offered by the core, answers accept/writeback
// combinationally in the issue cycle, executes accepted instructions and
// returns results in order through a small FIFO with valid/ready backpressure.
// Commit messages need no action (results are speculative); kill messages
// cancel the matching in-flight instruction or queued result.
//
// Optional feature (compile-time macro CVXIF_COPRO_MULTICYCLE_EN):
//   defined   - CUS_MADD (funct3 = 1) is accepted and completes after
//               funct7[1:0]+1 cycles; a busy counter blocks new issues.
//   undefined - CUS_MADD is rejected; no busy counter exists and
//               issue_ready_o depends only on FIFO space.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 synchronous flush of all in-flight work
//   issue_*                 issue request (valid/ready, instr, id, operands)
//   issue_accept_o          instruction accepted (combinational)
//   issue_writeback_o       accepted instruction writes rd
//   commit_*                commit/kill message for an instruction ID
//   result_valid_o/ready_i  result handshake
//   result_id/data/rd/we/exc/exccode_o  result payload (0 when no result)
// ---------------------------------------------------------------------------
module cvxif_copro_responder #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ID_WIDTH   = 3,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,

    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,

    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,

    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                result_exc_o,
    output logic [5:0]          result_exccode_o
);

    localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
    localparam logic [2:0] F3_ADD         = 3'd0;
    localparam logic [2:0] F3_MADD        = 3'd1;
    localparam logic [2:0] F3_NOP         = 3'd2;
    localparam logic [2:0] F3_EXC         = 3'd3;
    localparam logic [5:0] EXCCODE_ILLEGAL = 6'd2;

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [XLEN-1:0]     data;
        logic [4:0]          rd;
        logic                we;
        logic                exc;
        logic [5:0]          exccode;
    } result_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs_sum;
    logic            dec_accept;
    logic            dec_writeback;
    logic            dec_is_madd;
    result_t         dec_result;
    logic            unused_instr;

    assign opcode       = issue_instr_i[6:0];
    assign funct3       = issue_instr_i[14:12];
    assign rs_sum       = issue_rs1_i + issue_rs2_i;
    assign unused_instr = ^issue_instr_i[31:15];

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        dec_accept    = 1'b0;
        dec_writeback = 1'b0;
        dec_is_madd   = 1'b0;
        dec_result    = '0;
        dec_result.id = issue_id_i;
        if (opcode == OPCODE_CUSTOM3) begin
            case (funct3)
                F3_ADD: begin
                    if (issue_rs_valid_i == 2'b11) begin
                        dec_accept      = 1'b1;
                        dec_writeback   = 1'b1;
                        dec_result.data = rs_sum;
                        dec_result.rd   = issue_instr_i[11:7];
                        dec_result.we   = 1'b1;
                    end
                end
                F3_MADD: begin
`ifdef CVXIF_COPRO_MULTICYCLE_EN
                    if (issue_rs_valid_i == 2'b11) begin
                        dec_accept      = 1'b1;
                        dec_writeback   = 1'b1;
                        dec_is_madd     = 1'b1;
                        dec_result.data = rs_sum;
                        dec_result.rd   = issue_instr_i[11:7];
                        dec_result.we   = 1'b1;
                    end
`endif
                end
                F3_NOP: begin
                    dec_accept = 1'b1;
                end
                F3_EXC: begin
                    dec_accept         = 1'b1;
                    dec_result.exc     = 1'b1;
                    dec_result.exccode = EXCCODE_ILLEGAL;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue handshake and kill detection
    // ------------------------------------------------------------------
    logic             kill_valid;
    logic             kill_hits_issue;
    logic             issue_fire;
    logic             issue_take;
    logic             single_push;
    logic             busy_idle;
    logic             madd_push;
    logic             push_valid;
    result_t          push_entry;
    logic [CNT_W-1:0] cnt_q;

    assign kill_valid      = commit_valid_i & commit_kill_i;
    assign kill_hits_issue = kill_valid & (commit_id_i == issue_id_i);

    // An issue presented during a flush is dropped outright.
    assign issue_fire  = issue_valid_i & issue_ready_o & ~flush_i;
    assign issue_take  = issue_fire & dec_accept & ~kill_hits_issue;
    assign single_push = issue_take & ~dec_is_madd;

    // No full-FIFO bypass: a pop in the same cycle does not open a slot.
    assign issue_ready_o     = busy_idle & (cnt_q < DEPTH_C);
    assign issue_accept_o    = issue_valid_i & dec_accept;
    assign issue_writeback_o = issue_valid_i & dec_writeback;

    // ------------------------------------------------------------------
    // Multi-cycle execution (busy counter)
    // ------------------------------------------------------------------
`ifdef CVXIF_COPRO_MULTICYCLE_EN
    logic [2:0] busy_cnt_q;
    logic [2:0] busy_cnt_d;
    result_t    pend_q;
    logic       madd_kill;
    logic       madd_load;

    assign busy_idle = (busy_cnt_q == 3'd0);
    assign madd_kill = kill_valid & ~busy_idle & (commit_id_i == pend_q.id);
    assign madd_load = issue_take & dec_is_madd;
    // The result is pushed on the 1 -> 0 transition of the counter.
    assign madd_push = (busy_cnt_q == 3'd1) & ~madd_kill & ~flush_i;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (flush_i || madd_kill) begin
            busy_cnt_d = 3'd0;
        end else if (!busy_idle) begin
            busy_cnt_d = busy_cnt_q - 3'd1;
        end else if (madd_load) begin
            busy_cnt_d = {1'b0, issue_instr_i[26:25]} + 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_cnt_q <= 3'd0;
            pend_q     <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            if (madd_load) begin
                pend_q <= dec_result;
            end
        end
    end

    assign push_entry = madd_push ? pend_q : dec_result;
`else
    assign busy_idle  = 1'b1;
    assign madd_push  = 1'b0;
    assign push_entry = dec_result;
`endif

    assign push_valid = ~flush_i & (single_push | madd_push);

    // ------------------------------------------------------------------
    // In-order result FIFO
    // ------------------------------------------------------------------
    result_t                mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  dead_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic                   fifo_empty;
    logic                   head_dead;
    logic                   pop;
    result_t                head;

    assign fifo_empty = (cnt_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign head_dead  = dead_q[rd_ptr_q];
    // Killed entries leave the head silently without a handshake.
    assign pop        = ~fifo_empty & (head_dead | result_ready_i);

    // NOTE: the payload storage has no reset; an entry is only ever read
    // after being written, and occupancy is tracked by the reset pointers.
    always_ff @(posedge clk_i) begin
        if (push_valid) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            dead_q   <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            dead_q   <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_valid) - CNT_W'(pop);
            // Stale slots may match too; the push below rewrites the flag.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (kill_valid && (mem_q[i].id == commit_id_i)) begin
                    dead_q[i] <= 1'b1;
                end
            end
            if (push_valid) begin
                dead_q[wr_ptr_q] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result channel: payload is forced to zero whenever nothing is offered
    // ------------------------------------------------------------------
    assign result_valid_o   = ~fifo_empty & ~head_dead;
    assign result_id_o      = result_valid_o ? head.id      : '0;
    assign result_data_o    = result_valid_o ? head.data    : '0;
    assign result_rd_o      = result_valid_o ? head.rd      : '0;
    assign result_we_o      = result_valid_o & head.we;
    assign result_exc_o     = result_valid_o & head.exc;
    assign result_exccode_o = result_valid_o ? head.exccode : '0;

endmodule

// File: tb/tb_cvxif_copro_responder.sv
`timescale 1ns/1ps
module tb_cvxif_copro_responder;

    localparam int XLEN       = 64;
    localparam int ID_WIDTH   = 3;
    localparam int FIFO_DEPTH = 2;
    localparam logic [6:0] OPC = 7'b1111011;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                flush_i;
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;
    logic [1:0]          issue_rs_valid_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [XLEN-1:0]     result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;
    logic                result_exc_o;
    logic [5:0]          result_exccode_o;

    cvxif_copro_responder #(
        .XLEN(XLEN), .ID_WIDTH(ID_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_exc_o(result_exc_o), .result_exccode_o(result_exccode_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, rd, op};
    endfunction

    task automatic drive_issue(input logic [31:0] instr, input logic [63:0] rs1,
                               input logic [63:0] rs2, input logic [1:0] rv,
                               input logic [2:0] id);
        issue_valid_i    = 1'b1;
        issue_instr_i    = instr;
        issue_rs1_i      = rs1;
        issue_rs2_i      = rs2;
        issue_rs_valid_i = rv;
        issue_id_i       = id;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [1:0]  rv;
        logic [2:0]  id;
        logic        acc;
        logic        wb;
        logic        res;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic [5:0]  code;
    } vec_t;

    function automatic vec_t mkv(input string name, input logic [31:0] instr,
                                 input logic [63:0] rs1, input logic [63:0] rs2,
                                 input logic [1:0] rv, input logic [2:0] id,
                                 input logic acc, input logic wb, input logic res,
                                 input logic [63:0] data, input logic [4:0] rd,
                                 input logic we, input logic exc, input logic [5:0] code);
        vec_t v;
        v.name = name; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.rv = rv; v.id = id;
        v.acc = acc; v.wb = wb; v.res = res; v.data = data; v.rd = rd;
        v.we = we; v.exc = exc; v.code = code;
        return v;
    endfunction

    localparam int NV = 9;
    vec_t vecs [NV];

    logic [2:0]  got_id   [3];
    logic [63:0] got_data [3];
    int          got_n;
    logic        seen;
    logic        fired;

    initial begin
        vecs[0] = mkv("add_basic", mk_instr(7'd0, 3'd0, 5'd3, OPC), 64'd5, 64'd7, 2'b11, 3'd1,
                      1, 1, 1, 64'd12, 5'd3, 1, 0, 6'd0);
        vecs[1] = mkv("add_wrap", mk_instr(7'd0, 3'd0, 5'd10, OPC), '1, 64'd1, 2'b11, 3'd2,
                      1, 1, 1, 64'd0, 5'd10, 1, 0, 6'd0);
        vecs[2] = mkv("add_mix", mk_instr(7'd0, 3'd0, 5'd31, OPC), 64'h1234_5678_9ABC_DEF0,
                      64'h0FED_CBA9_8765_4321, 2'b11, 3'd0,
                      1, 1, 1, 64'h2222_2222_2222_2211, 5'd31, 1, 0, 6'd0);
        vecs[3] = mkv("bad_opcode", mk_instr(7'd0, 3'd0, 5'd3, 7'b0110011), 64'd5, 64'd7, 2'b11, 3'd3,
                      0, 0, 0, 64'd0, 5'd0, 0, 0, 6'd0);
        vecs[4] = mkv("add_rs1_only", mk_instr(7'd0, 3'd0, 5'd3, OPC), 64'd5, 64'd7, 2'b01, 3'd4,
                      0, 0, 0, 64'd0, 5'd0, 0, 0, 6'd0);
        vecs[5] = mkv("add_rs2_only", mk_instr(7'd0, 3'd0, 5'd3, OPC), 64'd5, 64'd7, 2'b10, 3'd4,
                      0, 0, 0, 64'd0, 5'd0, 0, 0, 6'd0);
        vecs[6] = mkv("nop", mk_instr(7'd0, 3'd2, 5'd4, OPC), 64'd9, 64'd9, 2'b00, 3'd6,
                      1, 0, 1, 64'd0, 5'd0, 0, 0, 6'd0);
        vecs[7] = mkv("exc", mk_instr(7'd0, 3'd3, 5'd4, OPC), 64'd9, 64'd9, 2'b00, 3'd7,
                      1, 0, 1, 64'd0, 5'd0, 0, 1, 6'd2);
        vecs[8] = mkv("bad_funct3", mk_instr(7'd0, 3'd5, 5'd3, OPC), 64'd5, 64'd7, 2'b11, 3'd5,
                      0, 0, 0, 64'd0, 5'd0, 0, 0, 6'd0);

        rst_ni = 1'b0; flush_i = 1'b0; issue_valid_i = 1'b0; issue_instr_i = '0;
        issue_id_i = '0; issue_rs1_i = '0; issue_rs2_i = '0; issue_rs_valid_i = '0;
        commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0; result_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("reset.issue_ready", issue_ready_o, 1);
        check("reset.result_valid", result_valid_o, 0);
        check("reset.accept", issue_accept_o, 0);
        check("reset.writeback", issue_writeback_o, 0);
        check("reset.result_data", result_data_o, 0);
        rst_ni = 1'b1;

        // Single-cycle table: issue, then check the result one cycle later
        for (int i = 0; i < NV; i++) begin
            tick();
            drive_issue(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].rv, vecs[i].id);
            result_ready_i = 1'b1;
            #1;
            check({vecs[i].name, ".issue_ready"}, issue_ready_o, 1);
            check({vecs[i].name, ".accept"}, issue_accept_o, vecs[i].acc);
            check({vecs[i].name, ".writeback"}, issue_writeback_o, vecs[i].wb);
            tick();
            issue_valid_i = 1'b0;
            #1;
            check({vecs[i].name, ".result_valid"}, result_valid_o, vecs[i].res);
            check({vecs[i].name, ".result_id"}, result_id_o, vecs[i].res ? vecs[i].id : 3'd0);
            check({vecs[i].name, ".result_data"}, result_data_o, vecs[i].data);
            check({vecs[i].name, ".result_rd"}, result_rd_o, vecs[i].rd);
            check({vecs[i].name, ".result_we"}, result_we_o, vecs[i].we);
            check({vecs[i].name, ".result_exc"}, result_exc_o, vecs[i].exc);
            check({vecs[i].name, ".result_exccode"}, result_exccode_o, vecs[i].code);
        end

        // MADD, latency funct7[1:0]+1 = 4
        tick();
        drive_issue(mk_instr(7'b0000011, 3'd1, 5'd9, OPC), 64'd100, 64'd23, 2'b11, 3'd2);
        #1;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
        check("madd.accept", issue_accept_o, 1);
        check("madd.writeback", issue_writeback_o, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            issue_valid_i = 1'b0;
            #1;
            check("madd.ready_low", issue_ready_o, 0);
            check("madd.no_early_result", result_valid_o, 0);
        end
        tick();
        #1;
        check("madd.ready_back", issue_ready_o, 1);
        check("madd.result_valid", result_valid_o, 1);
        check("madd.result_data", result_data_o, 64'd123);
        check("madd.result_id", result_id_o, 3'd2);
        check("madd.result_rd", result_rd_o, 5'd9);
        check("madd.result_we", result_we_o, 1);
`else
        check("madd_rej.accept", issue_accept_o, 0);
        check("madd_rej.writeback", issue_writeback_o, 0);
        seen = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            issue_valid_i = 1'b0;
            #1;
            if (result_valid_o || !issue_ready_o) seen = 1'b1;
        end
        check("madd_rej.no_result_ready_high", seen, 0);
`endif

        // Backpressure: third ADD stalls, then results drain in order
        tick();
        issue_valid_i = 1'b0;
        tick();
        result_ready_i = 1'b0;
        drive_issue(mk_instr(7'd0, 3'd0, 5'd1, OPC), 64'd10, 64'd1, 2'b11, 3'd1);
        #1;
        check("bp.ready_first", issue_ready_o, 1);
        tick();
        drive_issue(mk_instr(7'd0, 3'd0, 5'd2, OPC), 64'd20, 64'd1, 2'b11, 3'd2);
        #1;
        check("bp.ready_second", issue_ready_o, 1);
        tick();
        drive_issue(mk_instr(7'd0, 3'd0, 5'd3, OPC), 64'd30, 64'd1, 2'b11, 3'd3);
        #1;
        check("bp.third_stalls", issue_ready_o, 0);
        check("bp.head_valid", result_valid_o, 1);
        check("bp.head_id", result_id_o, 3'd1);
        tick();
        #1;
        check("bp.still_stalled", issue_ready_o, 0);
        check("bp.head_id_held", result_id_o, 3'd1);
        check("bp.head_data_held", result_data_o, 64'd11);
        tick();
        result_ready_i = 1'b1;
        #1;
        got_n = 0;
        for (int c = 0; c < 20 && got_n < 3; c++) begin
            fired = issue_valid_i && issue_ready_o;
            if (result_valid_o && result_ready_i) begin
                got_id[got_n]   = result_id_o;
                got_data[got_n] = result_data_o;
                got_n++;
            end
            tick();
            if (fired) issue_valid_i = 1'b0;
            #1;
        end
        issue_valid_i = 1'b0;
        check("bp.result_count", got_n, 3);
        if (got_n == 3) begin
            for (int j = 0; j < 3; j++) begin
                check("bp.order_id", got_id[j], j + 1);
                check("bp.order_data", got_data[j], 64'((j + 1) * 10 + 1));
            end
        end

        // Kill of a queued ADD: the dead head is skipped, next result follows
        tick();
        result_ready_i = 1'b0;
        drive_issue(mk_instr(7'd0, 3'd0, 5'd5, OPC), 64'd50, 64'd1, 2'b11, 3'd5);
        tick();
        drive_issue(mk_instr(7'd0, 3'd0, 5'd6, OPC), 64'd60, 64'd1, 2'b11, 3'd6);
        tick();
        issue_valid_i = 1'b0;
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 3'd5;
        #1;
        check("kill_q.before_kill_valid", result_valid_o, 1);
        check("kill_q.before_kill_id", result_id_o, 3'd5);
        tick();
        commit_kill_i = 1'b0; commit_id_i = 3'd6;   // plain commit: no effect
        #1;
        check("kill_q.dead_hidden", result_valid_o, 0);
        tick();
        commit_valid_i = 1'b0;
        #1;
        check("kill_q.next_valid", result_valid_o, 1);
        check("kill_q.next_id", result_id_o, 3'd6);
        check("kill_q.next_data", result_data_o, 64'd61);
        result_ready_i = 1'b1;
        tick();
        #1;
        check("kill_q.drained", result_valid_o, 0);

        // Kill arriving together with the issue of the same ID
        tick();
        drive_issue(mk_instr(7'd0, 3'd0, 5'd7, OPC), 64'd1, 64'd1, 2'b11, 3'd6);
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 3'd6;
        #1;
        check("kill_issue.accept", issue_accept_o, 1);
        tick();
        issue_valid_i = 1'b0; commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        #1;
        check("kill_issue.no_result", result_valid_o, 0);

`ifdef CVXIF_COPRO_MULTICYCLE_EN
        // Kill of the in-flight MADD
        tick();
        drive_issue(mk_instr(7'b0000011, 3'd1, 5'd8, OPC), 64'd4, 64'd4, 2'b11, 3'd4);
        #1;
        check("kill_madd.accept", issue_accept_o, 1);
        tick();
        issue_valid_i = 1'b0;
        #1;
        check("kill_madd.busy", issue_ready_o, 0);
        tick();
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 3'd4;
        #1;
        check("kill_madd.busy_in_kill_cycle", issue_ready_o, 0);
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        #1;
        check("kill_madd.ready_next", issue_ready_o, 1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (result_valid_o) seen = 1'b1;
            tick();
        end
        check("kill_madd.no_result", seen, 0);
`endif

        // Flush with two queued results (and an issue that must be ignored)
        tick();
        result_ready_i = 1'b0;
        drive_issue(mk_instr(7'd0, 3'd0, 5'd1, OPC), 64'd1, 64'd1, 2'b11, 3'd1);
        tick();
        drive_issue(mk_instr(7'd0, 3'd0, 5'd2, OPC), 64'd2, 64'd1, 2'b11, 3'd2);
        tick();
        drive_issue(mk_instr(7'd0, 3'd0, 5'd3, OPC), 64'd3, 64'd1, 2'b11, 3'd3);
        flush_i = 1'b1;
        #1;
        check("flush.valid_before", result_valid_o, 1);
        tick();
        flush_i = 1'b0; issue_valid_i = 1'b0;
        #1;
        check("flush.valid_after", result_valid_o, 0);
        check("flush.ready_after", issue_ready_o, 1);
        check("flush.data_zero", result_data_o, 0);
        tick();
        flush_i = 1'b1; result_ready_i = 1'b1;
        drive_issue(mk_instr(7'd0, 3'd0, 5'd3, OPC), 64'd3, 64'd1, 2'b11, 3'd3);
        #1;
        check("flush_issue.ready", issue_ready_o, 1);
        tick();
        flush_i = 1'b0; issue_valid_i = 1'b0;
        #1;
        check("flush_issue.ignored", result_valid_o, 0);

        // Asynchronous reset in the middle of operation
        tick();
        result_ready_i = 1'b0;
        drive_issue(mk_instr(7'd0, 3'd0, 5'd2, OPC), 64'd8, 64'd1, 2'b11, 3'd7);
        tick();
        issue_valid_i = 1'b0;
        #1;
        check("rst_mid.queued", result_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid.valid_cleared", result_valid_o, 0);
        check("rst_mid.id_cleared", result_id_o, 0);
        check("rst_mid.ready", issue_ready_o, 1);
        tick();
        rst_ni = 1'b1;
        tick();
        #1;
        check("rst_mid.stays_empty", result_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
